// File: rtl/warp_regfile_p.sv
// -----------------------------------------------------------------------------
// warp_regfile_p
//
// SIMT register file organised as WARPS x REGS x LANES words of DATA_W bits.
// It sits between the warp scheduler/decode stage and the lane ALUs.
//
// Features
//   - Two read ports sharing one warp select. Each port has its own register
//     address and per-lane enables. Outputs are registered with one cycle of
//     latency.
//   - Write-first bypass. A read that hits the register being written in the
//     same cycle returns the new data.
//   - One write port with per-lane masking and its own warp select.
//   - Warp-clear engine. It zeroes one register of the selected warp per
//     cycle, and it never stalls user reads or writes.
//
// Ports
//   clk        : clock; all logic is on posedge
//   rst_n      : synchronous, active-low reset (storage is not reset)
//   rd_warp    : warp index shared by both read ports
//   read_en_0  : per-lane read enable, port 0
//   raddr_0    : register address, port 0
//   read_en_1  : per-lane read enable, port 1
//   raddr_1    : register address, port 1
//   write_en   : per-lane write enable
//   wr_warp    : warp index for the write
//   waddr      : register address for the write
//   wdata      : write data; lane i at [i*DATA_W +: DATA_W]
//   clr_req    : request to clear warp clr_warp (ignored while clearing)
//   clr_warp   : warp to clear
//   rdata_0/1  : registered read data, same lane packing as wdata
//   rvalid_0/1 : per-lane valid for rdata_0/1
//   clr_busy   : clear engine active (high for exactly REGS cycles)
//   clr_done   : one-cycle pulse after the last register is cleared
// -----------------------------------------------------------------------------
module warp_regfile_p #(
  parameter  int LANES  = 8,
  parameter  int REGS   = 16,
  parameter  int WARPS  = 8,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(REGS),
  localparam int WW     = $clog2(WARPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WW-1:0]           rd_warp,
  input  logic [LANES-1:0]        read_en_0,
  input  logic [AW-1:0]           raddr_0,
  input  logic [LANES-1:0]        read_en_1,
  input  logic [AW-1:0]           raddr_1,
  input  logic [LANES-1:0]        write_en,
  input  logic [WW-1:0]           wr_warp,
  input  logic [AW-1:0]           waddr,
  input  logic [LANES*DATA_W-1:0] wdata,
  input  logic                    clr_req,
  input  logic [WW-1:0]           clr_warp,
  output logic [LANES*DATA_W-1:0] rdata_0,
  output logic [LANES*DATA_W-1:0] rdata_1,
  output logic [LANES-1:0]        rvalid_0,
  output logic [LANES-1:0]        rvalid_1,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam logic [AW-1:0] REG_LAST = AW'(REGS - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  // Storage: no reset, so this can map onto plain flops or RAM.
  logic [DATA_W-1:0] r_mem [WARPS][REGS][LANES];

  // Clear engine state
  state_t            r_state;
  logic [WW-1:0]     r_cw;
  logic [AW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;

  // Read output registers
  logic [LANES*DATA_W-1:0] r_rdata_0;
  logic [LANES*DATA_W-1:0] r_rdata_1;
  logic [LANES-1:0]        r_rvalid_0;
  logic [LANES-1:0]        r_rvalid_1;

  // Combinational read path
  logic              w_clr_act;
  logic              w_wr_hit_0;
  logic              w_wr_hit_1;
  logic              w_clr_hit_0;
  logic              w_clr_hit_1;
  logic [DATA_W-1:0] w_rd_0 [LANES];
  logic [DATA_W-1:0] w_rd_1 [LANES];

  // The clear engine writes only on non-reset edges. A reset mid-clear
  // therefore leaves the register it was about to zero untouched.
  assign w_clr_act = (r_state == S_CLEAR) && rst_n;

  assign w_wr_hit_0  = (wr_warp == rd_warp) && (waddr == raddr_0);
  assign w_wr_hit_1  = (wr_warp == rd_warp) && (waddr == raddr_1);
  assign w_clr_hit_0 = w_clr_act && (r_cw == rd_warp) && (r_cnt == raddr_0);
  assign w_clr_hit_1 = w_clr_act && (r_cw == rd_warp) && (r_cnt == raddr_1);

  // Read value per lane. Priority: user write > clear > stored value.
  // This matches the value that the storage holds after this edge.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      w_rd_0[i] = r_mem[rd_warp][raddr_0][i];
      if (w_clr_hit_0) begin
        w_rd_0[i] = '0;
      end
      if (w_wr_hit_0 && write_en[i]) begin
        w_rd_0[i] = wdata[i*DATA_W +: DATA_W];
      end

      w_rd_1[i] = r_mem[rd_warp][raddr_1][i];
      if (w_clr_hit_1) begin
        w_rd_1[i] = '0;
      end
      if (w_wr_hit_1 && write_en[i]) begin
        w_rd_1[i] = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Storage update. The clear is issued before the user write so that the
  // later non-blocking assignment wins when both target the same lane.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (w_clr_act) begin
        r_mem[r_cw][r_cnt][i] <= '0;
      end
      if (write_en[i]) begin
        r_mem[wr_warp][waddr][i] <= wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read outputs. Disabled lanes keep their previous data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata_0  <= '0;
      r_rdata_1  <= '0;
      r_rvalid_0 <= '0;
      r_rvalid_1 <= '0;
    end else begin
      r_rvalid_0 <= read_en_0;
      r_rvalid_1 <= read_en_1;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (read_en_0[i]) begin
          r_rdata_0[i*DATA_W +: DATA_W] <= w_rd_0[i];
        end
        if (read_en_1[i]) begin
          r_rdata_1[i*DATA_W +: DATA_W] <= w_rd_1[i];
        end
      end
    end
  end

  // Clear FSM. clr_busy and clr_done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cw    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_cw    <= clr_warp;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == REG_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata_0  = r_rdata_0;
  assign rdata_1  = r_rdata_1;
  assign rvalid_0 = r_rvalid_0;
  assign rvalid_1 = r_rvalid_1;
  assign clr_busy = r_busy;
  assign clr_done = r_done;

endmodule
